// File: rtl/riscv_pkg.sv
// Shared RV32 fetch-side constants and the IF/ID payload layout used by decode.
package riscv_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: imem port, redirect input, and the IF/ID handshake toward decode.
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
);
  logic                  fetch_en;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_instr;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  id_ready;
  logic                  if_valid;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic [ADDR_WIDTH-1:0] if_pc_plus4;
  logic [DATA_WIDTH-1:0] if_instr;
  logic                  misalign_fault;
  logic [CNT_WIDTH-1:0]  fetch_count;

  // Fetch unit side
  modport master (
    input  fetch_en, imem_instr, redirect_valid, redirect_pc, id_ready,
    output imem_addr, if_valid, if_pc, if_pc_plus4, if_instr,
           misalign_fault, fetch_count
  );

  // Environment side: memory, branch unit and decode
  modport slave (
    output fetch_en, imem_instr, redirect_valid, redirect_pc, id_ready,
    input  imem_addr, if_valid, if_pc, if_pc_plus4, if_instr,
           misalign_fault, fetch_count
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: payload plus valid with flush/load/drain controls.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  load,
  input  logic                  drain,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic [DATA_WIDTH-1:0] instr_in,
  output logic                  valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic [DATA_WIDTH-1:0] instr
);

  // Flush beats load beats drain; drain only clears valid and keeps the payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      pc       <= '0;
      pc_plus4 <= '0;
      instr    <= DATA_WIDTH'(NOP_INSTR);
    end else if (flush) begin
      valid <= 1'b0;
      instr <= DATA_WIDTH'(NOP_INSTR);
    end else if (load) begin
      valid    <= 1'b1;
      pc       <= pc_in;
      pc_plus4 <= pc_in + ADDR_WIDTH'(INSTR_BYTES);
      instr    <= instr_in;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, addresses instruction memory, fills IF/ID, handles redirects.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned          CNT_WIDTH  = 32
) (
  input  logic            clk,
  input  logic            rst,
  fetch_unit_if.master    bus
);

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  slot_free;
  logic                  fetch;
  logic                  drain;

  assign bus.imem_addr = pc;

  // Fetch/redirect decisions and the next PC; a redirect always wins over a fetch.
  always_comb begin
    slot_free = !bus.if_valid || bus.id_ready;
    fetch     = bus.fetch_en && slot_free && !bus.redirect_valid;
    drain     = bus.id_ready && bus.if_valid && !fetch && !bus.redirect_valid;
    pc_next   = pc;
    if (bus.redirect_valid) begin
      pc_next = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    end else if (fetch) begin
      pc_next = pc + ADDR_WIDTH'(INSTR_BYTES);
    end
  end

  // PC, fault pulse and fetched-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc                 <= {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
      bus.misalign_fault <= 1'b0;
      bus.fetch_count    <= '0;
    end else begin
      pc                 <= pc_next;
      bus.misalign_fault <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
      if (fetch) begin
        bus.fetch_count <= bus.fetch_count + CNT_WIDTH'(1);
      end
    end
  end

  if_id_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.redirect_valid),
    .load     (fetch),
    .drain    (drain),
    .pc_in    (pc),
    .instr_in (bus.imem_instr),
    .valid    (bus.if_valid),
    .pc       (bus.if_pc),
    .pc_plus4 (bus.if_pc_plus4),
    .instr    (bus.if_instr)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, then random traffic against a spec-level model.
module tb_fetch_unit;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  fetch_unit #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESET_PC   (32'h0000_0000),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] prog [16];

  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    if (addr < 32'd64) return prog[addr[5:2]];
    return {addr[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  // Combinational instruction memory
  assign bus.imem_instr = imem_word(bus.imem_addr);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
  logic        m_valid, m_fault;
  logic [31:0] m_cnt;

  task automatic model_step(input logic r, input logic en, input logic rv,
                            input logic [31:0] rpc, input logic rdy);
    if (r) begin
      m_pc = 0; m_valid = 0; m_ipc = 0; m_ipc4 = 0; m_instr = NOP; m_fault = 0; m_cnt = 0;
    end else begin
      m_fault = 0;
      if (rv) begin
        m_pc    = rpc & ~32'd3;
        m_valid = 0;
        m_instr = NOP;
        m_fault = (rpc % 4) != 0;
      end else if (en && (!m_valid || rdy)) begin
        m_instr = imem_word(m_pc);
        m_ipc   = m_pc;
        m_ipc4  = m_pc + 4;
        m_valid = 1;
        m_pc    = m_pc + 4;
        m_cnt   = m_cnt + 1;
      end else if (rdy) begin
        m_valid = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, advance DUT and model, leave time 1 after the edge.
  task automatic cycle(input logic r, input logic en, input logic rv,
                       input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    rst                = r;
    bus.fetch_en       = en;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.id_ready       = rdy;
    @(posedge clk);
    model_step(r, en, rv, rpc, rdy);
    #1;
  endtask

  typedef struct {
    logic        r, en, rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_ipc, e_ipc4, e_instr, e_addr;
    logic        e_fault;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [19];

  initial begin
    prog[0]  = 32'h0050_0093; prog[1]  = 32'h0030_0113;
    prog[2]  = 32'h0020_81b3; prog[3]  = 32'h4020_8233;
    prog[4]  = 32'h0000_1111; prog[5]  = 32'h0000_2222;
    prog[6]  = 32'h0000_3333; prog[7]  = 32'h0000_4444;
    prog[8]  = 32'h0000_0297; prog[9]  = 32'h0042_8293;
    prog[10] = 32'h0000_5555; prog[11] = 32'h0000_6666;
    prog[12] = 32'h0000_7777; prog[13] = 32'h0000_8888;
    prog[14] = 32'h0000_9999; prog[15] = 32'h0000_aaaa;

    bus.fetch_en = 0; bus.redirect_valid = 0; bus.redirect_pc = 0; bus.id_ready = 0;

    //            r  en rv rpc           rdy | valid ipc           ipc4          instr         addr          flt cnt
    vecs[0]  = '{1, 0, 0, 32'h0,        0,    0, 32'h0,        32'h0,        NOP,          32'h0,        0, 0};
    vecs[1]  = '{0, 1, 0, 32'h0,        1,    1, 32'h0,        32'h4,        32'h00500093, 32'h4,        0, 1};
    vecs[2]  = '{0, 1, 0, 32'h0,        1,    1, 32'h4,        32'h8,        32'h00300113, 32'h8,        0, 2};
    vecs[3]  = '{0, 1, 0, 32'h0,        1,    1, 32'h8,        32'hC,        32'h002081b3, 32'hC,        0, 3};
    vecs[4]  = '{0, 1, 0, 32'h0,        0,    1, 32'h8,        32'hC,        32'h002081b3, 32'hC,        0, 3};
    vecs[5]  = '{0, 1, 0, 32'h0,        0,    1, 32'h8,        32'hC,        32'h002081b3, 32'hC,        0, 3};
    vecs[6]  = '{0, 1, 0, 32'h0,        0,    1, 32'h8,        32'hC,        32'h002081b3, 32'hC,        0, 3};
    vecs[7]  = '{0, 1, 0, 32'h0,        1,    1, 32'hC,        32'h10,       32'h40208233, 32'h10,       0, 4};
    vecs[8]  = '{0, 1, 1, 32'h20,       1,    0, 32'hC,        32'h10,       NOP,          32'h20,       0, 4};
    vecs[9]  = '{0, 1, 0, 32'h0,        1,    1, 32'h20,       32'h24,       32'h00000297, 32'h24,       0, 5};
    vecs[10] = '{0, 1, 1, 32'h22,       1,    0, 32'h20,       32'h24,       NOP,          32'h20,       1, 5};
    vecs[11] = '{0, 1, 0, 32'h0,        1,    1, 32'h20,       32'h24,       32'h00000297, 32'h24,       0, 6};
    vecs[12] = '{0, 1, 1, 32'hFFFFFFFC, 1,    0, 32'h20,       32'h24,       NOP,          32'hFFFFFFFC, 0, 6};
    vecs[13] = '{0, 1, 0, 32'h0,        1,    1, 32'hFFFFFFFC, 32'h0,        32'hA5FFFFFF, 32'h0,        0, 7};
    vecs[14] = '{0, 1, 0, 32'h0,        0,    1, 32'hFFFFFFFC, 32'h0,        32'hA5FFFFFF, 32'h0,        0, 7};
    vecs[15] = '{1, 1, 1, 32'h40,       0,    0, 32'h0,        32'h0,        NOP,          32'h0,        0, 0};
    vecs[16] = '{0, 0, 0, 32'h0,        1,    0, 32'h0,        32'h0,        NOP,          32'h0,        0, 0};
    vecs[17] = '{0, 1, 0, 32'h0,        0,    1, 32'h0,        32'h4,        32'h00500093, 32'h4,        0, 1};
    vecs[18] = '{0, 0, 0, 32'h0,        1,    0, 32'h0,        32'h4,        32'h00500093, 32'h4,        0, 1};

    for (int i = 0; i < 19; i++) begin
      cycle(vecs[i].r, vecs[i].en, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      check($sformatf("v%0d if_valid", i),    64'(bus.if_valid),       64'(vecs[i].e_valid));
      check($sformatf("v%0d if_pc", i),       64'(bus.if_pc),          64'(vecs[i].e_ipc));
      check($sformatf("v%0d if_pc_plus4", i), 64'(bus.if_pc_plus4),    64'(vecs[i].e_ipc4));
      check($sformatf("v%0d if_instr", i),    64'(bus.if_instr),       64'(vecs[i].e_instr));
      check($sformatf("v%0d imem_addr", i),   64'(bus.imem_addr),      64'(vecs[i].e_addr));
      check($sformatf("v%0d fault", i),       64'(bus.misalign_fault), 64'(vecs[i].e_fault));
      check($sformatf("v%0d count", i),       64'(bus.fetch_count),    64'(vecs[i].e_cnt));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic        r, en, rv, rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 49) == 0);
      en  = ($urandom_range(0, 9) < 8);
      rv  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 127));
      cycle(r, en, rv, rpc, rdy);
      check("rnd imem_addr",   64'(bus.imem_addr),      64'(m_pc));
      check("rnd if_valid",    64'(bus.if_valid),       64'(m_valid));
      check("rnd if_pc",       64'(bus.if_pc),          64'(m_ipc));
      check("rnd if_pc_plus4", 64'(bus.if_pc_plus4),    64'(m_ipc4));
      check("rnd if_instr",    64'(bus.if_instr),       64'(m_instr));
      check("rnd fault",       64'(bus.misalign_fault), 64'(m_fault));
      check("rnd count",       64'(bus.fetch_count),    64'(m_cnt));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
